// File: rtl/pcie_tlp_memreq_gen_pkg.sv
// Shared types, constants and byte-swap helpers for the memory-request
// TLP header generator and its tag allocator.
package pcie_tlp_memreq_gen_pkg;

   // Header in wire byte order: byte 0 occupies bits [7:0].
   typedef struct packed {
      logic [5:0]  addr_l;
      logic [1:0]  reserved;
      logic [23:0] addr_m;
      logic [31:0] addr_h;
      logic [3:0]  last_be;
      logic [3:0]  first_be;
      logic [7:0]  tag;
      logic [7:0]  req_id_l;
      logic [7:0]  req_id_h;
      logic [7:0]  length_l;
      logic        td;
      logic        ep;
      logic [1:0]  attr_l;
      logic [1:0]  at;
      logic [1:0]  length_h;
      logic        tg_h;
      logic [2:0]  tc;
      logic        tg_m;
      logic        attr_h;
      logic        ln;
      logic        th;
      logic [2:0]  fmt;
      logic [4:0]  tlp_type;
   } tlp_memory_req_hdr_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_EMIT
   } memreq_state_t;

   localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
   localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
   localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
   localparam logic [2:0] FMT_4DW_DATA   = 3'b011;
   localparam logic [4:0] TYPE_MEM       = 5'b00000;

   localparam int DEF_MAX_PAYLOAD_SIZE  = 128;
   localparam int DEF_MAX_READ_REQ_SIZE = 512;
   localparam int PAGE_BYTES            = 4096;
   localparam int TAG_W                 = 8;

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   function automatic logic [23:0] bswap24(input logic [23:0] v);
      return {v[7:0], v[15:8], v[23:16]};
   endfunction

endpackage

// File: rtl/pcie_tag_alloc.sv
// Read-tag allocator: rolling tag counter plus outstanding-tag count
// with full indication for flow control.
module pcie_tag_alloc
   import pcie_tlp_memreq_gen_pkg::*;
#(
   parameter int TAG_COUNT = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_i,
   input  logic             release_i,
   output logic [TAG_W-1:0] tag_o,
   output logic             full_o
);

   localparam int CW = $clog2(TAG_COUNT + 1);
   localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(TAG_COUNT - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TAG_COUNT);

   logic [TAG_W-1:0] tag_q;
   logic [CW-1:0]    cnt_q;
   logic             rel_eff;

   // A release with nothing outstanding is a stray pulse and is dropped.
   assign rel_eff = release_i && (cnt_q != '0);

   // Tag counter advances per allocation; outstanding count tracks alloc/release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= '0;
         cnt_q <= '0;
      end else begin
         if (alloc_i)
            tag_q <= (tag_q == TAG_LAST) ? '0 : tag_q + 1'b1;
         if (alloc_i && !rel_eff)
            cnt_q <= cnt_q + 1'b1;
         else if (!alloc_i && rel_eff)
            cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tag_o  = tag_q;
   assign full_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pcie_tlp_memreq_gen.sv
// Splits DMA memory requests into PCIe memory-request TLP headers.
// Optional PCIE_TLP_3DW_EN: 3DW headers for chunks below 4GB.
module pcie_tlp_memreq_gen
   import pcie_tlp_memreq_gen_pkg::*;
#(
   parameter int MAX_PAYLOAD_SIZE  = DEF_MAX_PAYLOAD_SIZE,
   parameter int MAX_READ_REQ_SIZE = DEF_MAX_READ_REQ_SIZE,
   parameter int LEN_WIDTH         = 16,
   parameter int TAG_COUNT         = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [15:0]          cfg_requester_id,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wr,
   input  logic [63:0]          req_addr,
   input  logic [LEN_WIDTH-1:0] req_len,
   output logic                 hdr_valid,
   input  logic                 hdr_ready,
   output logic [127:0]         hdr_data,
   output logic [9:0]           hdr_dw_len,
   output logic                 hdr_is_4dw,
   output logic                 hdr_last,
   input  logic                 cpl_tag_release
);

   localparam int RW = (LEN_WIDTH > 13) ? LEN_WIDTH : 14;

   memreq_state_t       state_q;
   logic [63:0]         addr_q;
   logic [LEN_WIDTH-1:0] rem_q;
   logic                wr_q;
   logic [12:0]         chunk_q;
   tlp_memory_req_hdr_t hdr_q;
   tlp_memory_req_hdr_t hdr_d;
   logic [9:0]          dw_len_q;
   logic                is4dw_q;
   logic                is4dw_d;
   logic                last_q;
   logic                valid_q;
   logic                ready_q;
   logic [RW-1:0]       rem_ext;
   logic [RW-1:0]       max_sz;
   logic [RW-1:0]       page_left;
   logic [RW-1:0]       chunk_d;
   logic [TAG_W-1:0]    tag_val;
   logic                tag_full;
   logic                tag_alloc;
   logic                unused_bits;

   assign unused_bits = ^{req_addr[1:0], req_len[1:0]};

   // Chunk = min(remaining, per-direction max, bytes left in 4KB page).
   always_comb begin
      rem_ext   = RW'(rem_q);
      max_sz    = wr_q ? RW'(MAX_PAYLOAD_SIZE)
                       : RW'(MAX_READ_REQ_SIZE);
      page_left = RW'(13'(PAGE_BYTES) - {1'b0, addr_q[11:0]});
      chunk_d   = rem_ext;
      if (max_sz < chunk_d)
         chunk_d = max_sz;
      if (page_left < chunk_d)
         chunk_d = page_left;
   end

   // Header fields for the chunk at the current address.
   always_comb begin
      hdr_d          = '0;
      hdr_d.tlp_type = TYPE_MEM;
      hdr_d.length_h = chunk_d[11:10];
      hdr_d.length_l = chunk_d[9:2];
      hdr_d.req_id_h = cfg_requester_id[15:8];
      hdr_d.req_id_l = cfg_requester_id[7:0];
      hdr_d.tag      = wr_q ? '0 : tag_val;
      hdr_d.first_be = 4'hF;
      hdr_d.last_be  = (chunk_d[12:2] == 11'd1) ? 4'h0 : 4'hF;
      hdr_d.fmt      = wr_q ? FMT_4DW_DATA : FMT_4DW_NODATA;
      hdr_d.addr_h   = bswap32(addr_q[63:32]);
      hdr_d.addr_m   = bswap24(addr_q[31:8]);
      hdr_d.addr_l   = addr_q[7:2];
      is4dw_d        = 1'b1;
`ifdef PCIE_TLP_3DW_EN
      if (addr_q[63:32] == '0) begin
         hdr_d.fmt    = wr_q ? FMT_3DW_DATA : FMT_3DW_NODATA;
         hdr_d.addr_h = bswap32(addr_q[31:0]);
         hdr_d.addr_m = '0;
         hdr_d.addr_l = '0;
         is4dw_d      = 1'b0;
      end
`endif
   end

   assign tag_alloc = valid_q && hdr_ready && !wr_q;

   // Request FSM: latch request, compute chunk, hold header until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         addr_q   <= '0;
         rem_q    <= '0;
         wr_q     <= 1'b0;
         chunk_q  <= '0;
         hdr_q    <= '0;
         dw_len_q <= '0;
         is4dw_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (req_valid && ready_q &&
                   req_len[LEN_WIDTH-1:2] != '0) begin
                  ready_q <= 1'b0;
                  addr_q  <= {req_addr[63:2], 2'b00};
                  rem_q   <= {req_len[LEN_WIDTH-1:2], 2'b00};
                  wr_q    <= req_wr;
                  state_q <= S_CALC;
               end
            end
            S_CALC: begin
               hdr_q    <= hdr_d;
               chunk_q  <= chunk_d[12:0];
               dw_len_q <= chunk_d[11:2];
               is4dw_q  <= is4dw_d;
               last_q   <= (rem_ext == chunk_d);
               valid_q  <= wr_q || !tag_full;
               state_q  <= S_EMIT;
            end
            S_EMIT: begin
               if (valid_q && hdr_ready) begin
                  valid_q <= 1'b0;
                  addr_q  <= addr_q + 64'(chunk_q);
                  rem_q   <= rem_q - LEN_WIDTH'(chunk_q);
                  if (last_q) begin
                     ready_q <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_CALC;
                  end
               end else if (!valid_q && !tag_full) begin
                  valid_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   pcie_tag_alloc #(
      .TAG_COUNT (TAG_COUNT)
   ) u_tag_alloc (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc_i   (tag_alloc),
      .release_i (cpl_tag_release),
      .tag_o     (tag_val),
      .full_o    (tag_full)
   );

   assign req_ready  = ready_q;
   assign hdr_valid  = valid_q;
   assign hdr_data   = hdr_q;
   assign hdr_dw_len = dw_len_q;
   assign hdr_is_4dw = is4dw_q;
   assign hdr_last   = last_q;

endmodule
